// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-issue instruction fetch stage. Fetches one word at a
//               time from instruction memory, holds it for decode until it is
//               acknowledged, then redirects the PC using the control unit's
//               resolution (halt > jump_register > jump > branch > sequential).
//
// Parameters  : RESET_PC     - start address after reset (word aligned)
// Macro       : LINK_PC8_EN  - when defined, link_addr = pc+8 (delay-slot
//                              convention); otherwise link_addr = pc+4
//
// Ports       : clk            in   clock, rising edge
//               rst_b          in   asynchronous active-low reset
//               imem_req       out  instruction-memory read request
//               imem_addr[31:0]out  fetch address (= pc)
//               imem_rdata[31:0] in instruction word
//               imem_ready     in   memory completion strobe
//               inst[31:0]     out  instruction presented to decode
//               inst_valid     out  inst holds an unacknowledged instruction
//               inst_ack       in   decode consumed inst
//               halted, jump_register, jump, branch  in  redirect resolution
//               rs_data[31:0]  in   jump_register target
//               pc[31:0]       out  address of current instruction
//               link_addr[31:0]out  return address for linking
//               halt_o         out  processor stopped
//               retired[31:0]  out  count of acknowledged non-halt insts
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        halted,
    input  logic        jump_register,
    input  logic        jump,
    input  logic        branch,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        halt_o,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Low address bits are forced to zero so pc is always word aligned.
    localparam logic [31:0] c_reset_pc = RESET_PC & 32'hFFFF_FFFC;

`ifdef LINK_PC8_EN
    localparam logic [31:0] c_link_ofs = 32'd8;
`else
    localparam logic [31:0] c_link_ofs = 32'd4;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_retired;
    logic [31:0] w_retired_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_jr_target;
    logic [31:0] w_j_target;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_jr_target = rs_data & 32'hFFFF_FFFC;
    assign w_j_target  = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};

    // ------------------------------------------------------------------------
    // State register. r_run clears asynchronously with reset and sets on the
    // first rising edge after release, so the memory request drops the moment
    // reset asserts and only resumes one edge after it is removed. Any
    // imem_ready seen while r_run is low is ignored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= FETCH;
            r_run     <= 1'b0;
            r_pc      <= c_reset_pc;
            r_inst    <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= 1'b1;
            r_pc      <= w_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, datapath update and state-decoded outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_retired_nxt = r_retired;
        imem_req      = 1'b0;
        inst_valid    = 1'b0;
        halt_o        = 1'b0;

        case (r_state)
            FETCH: begin
                imem_req = r_run;
                if (r_run && imem_ready) begin
                    w_inst_nxt  = imem_rdata;
                    w_state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ack) begin
                    if (halted) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_state_nxt   = FETCH;
                        w_retired_nxt = r_retired + 32'd1;
                        if (jump_register) begin
                            w_pc_nxt = w_jr_target;
                        end else if (jump) begin
                            w_pc_nxt = w_j_target;
                        end else if (branch) begin
                            w_pc_nxt = w_pc_plus4 + w_br_offset;
                        end else begin
                            w_pc_nxt = w_pc_plus4;
                        end
                    end
                end
            end

            HALT: begin
                halt_o = 1'b1;
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign retired   = r_retired;
    assign link_addr = r_pc + c_link_ofs;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Inputs change
//               1 ns after a rising edge; outputs are sampled at that point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ack = 1'b0;
    logic        halted = 1'b0;
    logic        jump_register = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        halt_o;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_ret  = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_ack      (inst_ack),
        .halted        (halted),
        .jump_register (jump_register),
        .jump          (jump),
        .branch        (branch),
        .rs_data       (rs_data),
        .pc            (pc),
        .link_addr     (link_addr),
        .halt_o        (halt_o),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One minimum-latency instruction: ready in the first FETCH cycle, ack in
    // the first ISSUE cycle. Entered 1 ns after a rising edge in FETCH.
    task automatic do_instr(input string tag, input logic [31:0] word,
                            input logic h, input logic jr, input logic j,
                            input logic br, input logic [31:0] rs,
                            input logic [31:0] exp_addr);
        check({tag, ".req"},  {31'd0, imem_req}, 32'd1);
        check({tag, ".addr"}, imem_addr, exp_addr);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check({tag, ".vld"},  {31'd0, inst_valid}, 32'd1);
        check({tag, ".inst"}, inst, word);
        inst_ack      = 1'b1;
        halted        = h;
        jump_register = jr;
        jump          = j;
        branch        = br;
        rs_data       = rs;
        @(posedge clk); #1;
        inst_ack      = 1'b0;
        halted        = 1'b0;
        jump_register = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        if (!h) exp_ret = exp_ret + 32'd1;
        check({tag, ".ret"}, retired, exp_ret);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.req",  {31'd0, imem_req},   32'd0);
        check("rst.pc",   pc,                  32'd0);
        check("rst.vld",  {31'd0, inst_valid}, 32'd0);
        check("rst.halt", {31'd0, halt_o},     32'd0);
        check("rst.ret",  retired,             32'd0);
        check("rst.inst", inst,                32'd0);

        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;

        // Sequential fetch 0,4,8 then 12 with retired = 3
        do_instr("seq0", 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0);
        do_instr("seq1", 32'h0000_0002, 0, 0, 0, 0, 0, 32'h4);
        do_instr("seq2", 32'h0000_0003, 0, 0, 0, 0, 0, 32'h8);
        check("seq.ret3", retired, 32'd3);
        check("seq.pc12", imem_addr, 32'hC);

        // Wait states on both handshakes
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ws.req",  {31'd0, imem_req},   32'd1);
        check("ws.vld0", {31'd0, inst_valid}, 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h2402_0005;
        @(posedge clk); #1;
        imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ws.inst", inst, 32'h2402_0005);
        check("ws.vld1", {31'd0, inst_valid}, 32'd1);
        check("ws.pc",   pc, 32'hC);
        check("ws.ret",  retired, 32'd3);
        inst_ack = 1'b1;
        @(posedge clk); #1;
        inst_ack = 1'b0;
        exp_ret = exp_ret + 32'd1;

        // Redirects
        do_instr("jr103", 32'h0, 0, 1, 0, 0, 32'h0000_0103, 32'h10);
        do_instr("br1",   32'h1000_FFFE, 0, 0, 0, 1, 0, 32'h100);
        do_instr("jr100", 32'h0, 0, 1, 0, 0, 32'h0000_0100, 32'hFC);
        do_instr("br0",   32'h1000_FFFE, 0, 0, 0, 0, 0, 32'h100);
        do_instr("jr40",  32'h0, 0, 1, 0, 0, 32'h0000_0040, 32'h104);
        do_instr("jbr",   32'h0800_0010, 0, 0, 1, 1, 0, 32'h40);
        do_instr("jrall", 32'h0800_0010, 0, 1, 1, 1, 32'h0000_0203, 32'h40);
        do_instr("jr1k",  32'h0, 0, 1, 0, 0, 32'h0000_1000, 32'h200);
`ifdef LINK_PC8_EN
        check("link", link_addr, 32'h0000_1008);
`else
        check("link", link_addr, 32'h0000_1004);
`endif
        do_instr("jrtop", 32'h0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h1000);
        do_instr("wrap",  32'h0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        check("wrap.addr", imem_addr, 32'h0);

        // Halt has priority over a simultaneous jump_register
        do_instr("halt", 32'h0000_000D, 1, 1, 0, 0, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("halt.req", {31'd0, imem_req}, 32'd0);
            if (i == 0) begin
                check("halt.o",   {31'd0, halt_o}, 32'd1);
                check("halt.vld", {31'd0, inst_valid}, 32'd0);
            end
            @(posedge clk); #1;
        end
        check("halt.ret", retired, exp_ret);
        check("halt.pc",  pc, 32'h0);

        // Reset out of HALT
        #2 rst_b = 1'b0;
        #1;
        check("hrst.halt", {31'd0, halt_o}, 32'd0);
        check("hrst.ret",  retired, 32'd0);
        exp_ret = 32'd0;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        do_instr("resume", 32'h0000_0011, 0, 0, 0, 0, 0, 32'h0);

        // Reset mid-fetch with a late ready
        check("mid.req1", {31'd0, imem_req}, 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("mid.reqdrop", {31'd0, imem_req}, 32'd0);
        check("mid.pc",      pc, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_b = 1'b1;
        check("mid.noreq", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check("mid.vld",  {31'd0, inst_valid}, 32'd0);
        check("mid.inst", inst, 32'h0);
        exp_ret = 32'd0;
        do_instr("post", 32'h0000_1234, 0, 0, 0, 0, 0, 32'h0);
        check("post.pc", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_b  input  1  asynchronous, active-low reset.
REQ-003 imem_req  output  1  instruction-memory read request, held until imem_ready.
REQ-004 imem_addr  output  32  word-aligned fetch address, equal to pc while imem_req=1.
REQ-005 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-006 imem_ready  input  1  memory completion strobe, ignored when imem_req=0.
REQ-007 inst  output  32  instruction presented to decode and control.
REQ-008 inst_valid  output  1  inst holds a fetched, not-yet-acknowledged instruction.
REQ-009 inst_ack  input  1  decode consumed inst; redirect inputs are sampled in the same cycle.
REQ-010 halted, jump_register, jump, branch  input  1 each  control-unit resolution for the current inst.
REQ-011 rs_data  input  32  register-file rs value, the jump_register target.
REQ-012 pc  output  32  address of the current instruction.
REQ-013 link_addr  output  32  return address for JAL linking.
REQ-014 halt_o  output  1  processor stopped.
REQ-015 retired  output  32  count of acknowledged non-halt instructions.

Function
REQ-016 FSM states are FETCH, ISSUE and HALT; a parameter RESET_PC (default 32'h0000_0000) sets the start address.
REQ-017 FETCH behaviour:
- imem_req=1 and imem_addr=pc.
- When imem_ready=1, imem_rdata is latched into inst and the FSM moves to ISSUE.
- inst_valid=1 from the next cycle.
REQ-018 ISSUE behaviour:
- imem_req=0, inst_valid=1, and inst stays stable until inst_ack=1.
- inst_ack=0 holds all state.
REQ-019 On inst_ack in ISSUE, the next PC is chosen by fixed priority:
- halted: go to HALT; pc and retired are unchanged.
- jump_register: next pc = {rs_data[31:2],2'b00}.
- jump: next pc = {pc_plus4[31:28], inst[25:0], 2'b00}.
- branch: next pc = pc_plus4 + (sign-extended inst[15:0] << 2).
- none asserted: next pc = pc_plus4.
REQ-020 On any non-halted inst_ack, the FSM returns to FETCH and retired increments by 1.
REQ-021 HALT behaviour:
- halt_o=1, imem_req=0, inst_valid=0.
- HALT is exited only by reset.
REQ-022 Simultaneous redirect inputs are legal and resolved only by the REQ-019 priority.
REQ-023 Arithmetic and address rules:
- All PC arithmetic is 32-bit modulo 2^32; pc 32'hFFFF_FFFC plus 4 wraps to 32'h0000_0000.
- pc[1:0] is always 2'b00.
REQ-024 retired wraps from 32'hFFFF_FFFF to 0.
REQ-025 Latency:
- Minimum is 2 cycles per instruction: imem_ready in the first FETCH cycle, inst_ack in the first ISSUE cycle.
- Each wait cycle on either handshake adds one cycle.

Reset
REQ-026 While rst_b=0, the block forces: pc=RESET_PC, FSM=FETCH, inst=0, inst_valid=0, halt_o=0, retired=0.
REQ-027 Assertion mid-fetch drops imem_req immediately, with no clock required; a late imem_ready is then ignored.
REQ-028 imem_req=1 resumes on the first rising edge after rst_b rises.

Configuration
REQ-029 With macro LINK_PC8_EN defined, link_addr = pc+8 (delay-slot convention).
REQ-030 With LINK_PC8_EN undefined, link_addr = pc+4; no other behaviour differs.

Verification
REQ-031 Reset release, imem_ready same cycle, inst_ack next cycle, no redirects → pc sequence 0,4,8,12 at 2 cycles per instruction; retired=3 after three acks.
REQ-032 pc=0x100, inst=0x1000FFFE, branch=1 on ack → next imem_addr=0xFC; with branch=0 → 0x104.
REQ-033 pc=0x0000_0040, inst=0x08000010, jump=1 and branch=1 together → next pc=0x40 (jump wins); jump_register=1 with rs_data=0x203 → next pc=0x200.
REQ-034 halted=1 on ack → halt_o=1, imem_req stays 0 for 10 cycles, retired unchanged; rst_b low then high → fetch resumes at RESET_PC.
REQ-035 rst_b driven low mid-FETCH with imem_ready delayed 3 cycles → imem_req drops without a clock edge, late ready is ignored, and the first fetch after release is address 0.
REQ-036 pc=0x1000 → link_addr=0x1008 with LINK_PC8_EN, 0x1004 without; a fetch at pc 0xFFFF_FFFC with no redirect → next imem_addr=0.
